// File: rtl/reduction_frame_accumulator.sv
// Folds each frame of WIDTH-bit beats into AND/OR/XOR reductions plus a saturating beat count.
// Latency: result valid the cycle after the in_last beat is accepted; frame period = beats + 1.
// Backpressure: in_ready drops while a result is held; released by out_valid && out_ready.
// Optional REDUCTION_INV_OUTPUTS_EN adds registered out_nand/out_nor/out_xnor.
module reduction_frame_accumulator #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_and,
    output logic               out_or,
    output logic               out_xor,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
`ifdef REDUCTION_INV_OUTPUTS_EN
    ,
    output logic               out_nand,
    output logic               out_nor,
    output logic               out_xnor
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic               and_acc, or_acc, xor_acc, ovf_acc;
    logic [COUNT_W-1:0] cnt_acc;

    logic               nxt_and, nxt_or, nxt_xor, nxt_ovf;
    logic [COUNT_W-1:0] nxt_cnt;
    logic               accept;

    assign accept = in_valid && in_ready;

    // First beat loads the accumulators; later beats fold into them.
    always_comb begin
        nxt_and = &in_data;
        nxt_or  = |in_data;
        nxt_xor = ^in_data;
        nxt_cnt = COUNT_W'(1);
        nxt_ovf = 1'b0;
        if (state == ACCUM) begin
            nxt_and = and_acc & (&in_data);
            nxt_or  = or_acc | (|in_data);
            nxt_xor = xor_acc ^ (^in_data);
            if (cnt_acc == CNT_MAX) begin
                nxt_cnt = cnt_acc;
                nxt_ovf = 1'b1;
            end else begin
                nxt_cnt = cnt_acc + COUNT_W'(1);
                nxt_ovf = ovf_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_and   <= 1'b0;
            out_or    <= 1'b0;
            out_xor   <= 1'b0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            and_acc   <= 1'b0;
            or_acc    <= 1'b0;
            xor_acc   <= 1'b0;
            cnt_acc   <= '0;
            ovf_acc   <= 1'b0;
`ifdef REDUCTION_INV_OUTPUTS_EN
            out_nand  <= 1'b0;
            out_nor   <= 1'b0;
            out_xnor  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_and   <= nxt_and;
                            out_or    <= nxt_or;
                            out_xor   <= nxt_xor;
                            out_count <= nxt_cnt;
                            out_ovf   <= nxt_ovf;
`ifdef REDUCTION_INV_OUTPUTS_EN
                            out_nand  <= ~nxt_and;
                            out_nor   <= ~nxt_or;
                            out_xnor  <= ~nxt_xor;
`endif
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            and_acc <= nxt_and;
                            or_acc  <= nxt_or;
                            xor_acc <= nxt_xor;
                            cnt_acc <= nxt_cnt;
                            ovf_acc <= nxt_ovf;
                            state   <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result outputs keep the last frame after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        and_acc   <= 1'b0;
                        or_acc    <= 1'b0;
                        xor_acc   <= 1'b0;
                        cnt_acc   <= '0;
                        ovf_acc   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduction_frame_accumulator.sv
// Directed bench for reduction_frame_accumulator with a frame-level reference model.
module tb_reduction_frame_accumulator;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 2;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic               out_and, out_or, out_xor, out_ovf;
    logic [COUNT_W-1:0] out_count;
`ifdef REDUCTION_INV_OUTPUTS_EN
    logic               out_nand, out_nor, out_xnor;
`endif

    int checks = 0;
    int fails  = 0;

    reduction_frame_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
        .out_count(out_count), .out_ovf(out_ovf)
`ifdef REDUCTION_INV_OUTPUTS_EN
        , .out_nand(out_nand), .out_nor(out_nor), .out_xnor(out_xnor)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect accepted beats, reduce over every bit when the frame closes.
    logic [WIDTH-1:0] m_q[$];
    bit m_hold = 0, m_and = 0, m_or = 0, m_xor = 0, m_ovf = 0;
    int m_cnt = 0, m_n = 0;
    bit started = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_q.delete();
            m_hold = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            m_q.push_back(in_data);
            if (in_last) begin
                m_and = 1; m_or = 0; m_xor = 0;
                foreach (m_q[i])
                    for (int b = 0; b < WIDTH; b++) begin
                        m_and = m_and & m_q[i][b];
                        m_or  = m_or  | m_q[i][b];
                        m_xor = m_xor ^ m_q[i][b];
                    end
                m_n   = m_q.size();
                m_cnt = (m_n > CMAX) ? CMAX : m_n;
                m_ovf = (m_n > CMAX);
                m_q.delete();
                m_hold = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", 32'(in_ready), 32'(!m_hold));
            chk("m_out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                chk("m_and", 32'(out_and), 32'(m_and));
                chk("m_or", 32'(out_or), 32'(m_or));
                chk("m_xor", 32'(out_xor), 32'(m_xor));
                chk("m_count", 32'(out_count), 32'(m_cnt));
                chk("m_ovf", 32'(out_ovf), 32'(m_ovf));
`ifdef REDUCTION_INV_OUTPUTS_EN
                chk("m_nand", 32'(out_nand), 32'(!m_and));
                chk("m_nor", 32'(out_nor), 32'(!m_or));
                chk("m_xnor", 32'(out_xnor), 32'(!m_xor));
`endif
            end
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the in_last beat was taken, with out_ready=1.
    task automatic expect_res(input string tag, input bit a, input bit o, input bit x,
                              input int c, input bit v);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_and"}, 32'(out_and), 32'(a));
        chk({tag, "_or"}, 32'(out_or), 32'(o));
        chk({tag, "_xor"}, 32'(out_xor), 32'(x));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(v));
`ifdef REDUCTION_INV_OUTPUTS_EN
        chk({tag, "_nand"}, 32'(out_nand), 32'(!a));
        chk({tag, "_nor"}, 32'(out_nor), 32'(!o));
        chk({tag, "_xnor"}, 32'(out_xnor), 32'(!x));
`endif
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic expect_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_outs"}, {27'd0, out_and, out_or, out_xor, out_ovf, 1'b0}, 32'd0);
        chk({tag, "_count"}, 32'(out_count), 32'd0);
`ifdef REDUCTION_INV_OUTPUTS_EN
        chk({tag, "_inv"}, {29'd0, out_nand, out_nor, out_xnor}, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        expect_reset_vals("reset");
        rst = 1'b0;

        send_beat(8'b1101_0010, 1'b1);
        expect_res("single", 0, 1, 0, 1, 0);

        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b1);
        expect_res("ff_ff", 1, 1, 0, 2, 0);

        send_beat(8'hFF, 1'b0);
        send_beat(8'h01, 1'b1);
        expect_res("ff_01", 0, 1, 1, 2, 0);

        // Held result under backpressure while a beat is offered.
        out_ready = 1'b0;
        send_beat(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_res", {27'd0, out_and, out_or, out_xor, out_count}, 32'd1);
            if (i == 0) begin
                in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
            end
            if (i == 3) begin
                in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("bp_release", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) send_beat(8'h80, i == 4);
        expect_res("ovf", 0, 1, 1, 3, 1);
        send_beat(8'h80, 1'b1);
        expect_res("after_ovf", 0, 1, 1, 1, 0);

        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_reset_vals("mid_reset");
        rst = 1'b0;
        send_beat(8'h0F, 1'b1);
        expect_res("post_reset", 0, 1, 0, 1, 0);

        // Reset while a result is pending discards it.
        out_ready = 1'b0;
        send_beat(8'hAA, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_reset_vals("hold_reset");
        rst = 1'b0; out_ready = 1'b1;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/reduction_frame_accumulator.md
# reduction_frame_accumulator

Streaming front-end for the reduction stage. Accepts WIDTH-bit data beats over a valid/ready handshake, grouped into frames by `in_last`, and folds every bit of every beat into frame-wide AND, OR and XOR reductions plus a beat count. One result per frame is presented on a valid/ready output and held until consumed. This feeds the reduction stage with per-frame summary bits instead of single words.

## Interface
- `WIDTH`, 8, data beat width in bits (≥1)
- `COUNT_W`, 8, beat-counter width in bits (≥2)

- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  beat offered
- `in_ready`  output  1  block can accept a beat
- `in_data`  input  WIDTH  beat payload
- `in_last`  input  1  beat closes the current frame
- `out_valid`  output  1  frame result available
- `out_ready`  input  1  consumer accepts result
- `out_and`  output  1  AND of all bits of all beats in frame
- `out_or`  output  1  OR of all bits of all beats in frame
- `out_xor`  output  1  XOR (parity) of all bits of all beats in frame
- `out_count`  output  COUNT_W  beats in frame, saturating
- `out_ovf`  output  1  beat count exceeded 2^COUNT_W−1
- `out_nand`, `out_nor`, `out_xnor`  output  1 each  present only with `REDUCTION_INV_OUTPUTS_EN`

## Operation
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- States: IDLE (no beat of current frame yet), ACCUM (≥1 beat accepted, no `in_last`), HOLD (result presented).
- Beat accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE/ACCUM, 0 in HOLD.
- First beat of a frame (IDLE): accumulators load `&in_data`, `|in_data`, `^in_data`, count = 1.
- Later beats (ACCUM): and_acc &= `&in_data`, or_acc |= `|in_data`, xor_acc ^= `^in_data`, count += 1.
- Count saturates at 2^COUNT_W−1; any accepted beat while saturated sets the sticky ovf bit for the frame.
- Accepted beat with `in_last`=1 in IDLE or ACCUM: final values (including this beat) registered onto outputs, go HOLD.
- IDLE/ACCUM with no accepted beat: state and accumulators unchanged.
- HOLD: `out_valid`=1; outputs stable until `out_valid && out_ready`. On that handshake go IDLE, clear accumulators and ovf.
- Single-beat frame (`in_last` on first beat) is legal: count = 1.
- Result outputs are don't-care while `out_valid`=0; implementation holds the last frame's values.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_and`=0, `out_or`=0, `out_xor`=0, `out_count`=0, `out_ovf`=0, inverted outputs=0; state IDLE, accumulators and ovf cleared.
- Reset dominates all other inputs in the same edge; mid-frame or mid-HOLD reset discards the partial or pending frame.
- Latency: `out_valid` rises the cycle after the edge accepting the `in_last` beat.
- `out_ready` is sampled only while `out_valid`=1; `out_ready` high in the first HOLD cycle gives a one-cycle result.
- After the output handshake, `in_ready` returns to 1 in the next cycle. Minimum frame period is beats + 1 cycles. No input/output overlap.
- `in_ready` depends only on state, never combinationally on `out_ready`.

## Configuration
- `REDUCTION_INV_OUTPUTS_EN` defined: ports `out_nand`, `out_nor`, `out_xnor` exist and are registered alongside the base outputs. They equal the inversions of `out_and`, `out_or` and `out_xor` while `out_valid`=1, and are 0 in reset.
- Not defined: those ports and their registers are absent; all other behaviour is identical.

## Test plan
- Single beat 8'b11010010 with `in_last`, `out_ready`=1 → next cycle `out_valid`=1, and=0, or=1, xor=0, count=1, ovf=0; one cycle later `in_ready`=1.
- Frame 8'hFF, 8'hFF (last) → and=1, or=1, xor=0, count=2; with macro, nand=0, nor=0, xnor=1.
- Frame 8'hFF, 8'h01 (last) → and=0, or=1, xor=1, count=2.
- Backpressure: frame 8'h00 (last), `out_ready` held 0 for 3 cycles → outputs hold and=0, or=0, xor=0, count=1 for 4 cycles; `in_ready`=0 throughout; `in_valid` beats during HOLD are not accepted.
- Overflow with COUNT_W=2: 5 beats of 8'h80, last on the 5th → count=3, ovf=1, xor=1; next frame of 1 beat → ovf=0, count=1.
- Reset mid-frame after 2 beats of 8'hFF, then frame 8'h0F (last) → and=0, or=1, xor=0, count=1; reset outputs match the reset values listed under Timing.
